// File: rtl/imem_fetch_responder.sv
// Instruction fetch responder: direct-mapped, one-word-per-line I-cache in front of a
// req/ack memory bus. Misses stall the PC until the refill lands.
module imem_fetch_responder #(
    parameter int LINES = 16,
    localparam int INDEX_W = $clog2(LINES),
    localparam int TAG_W = 29 - INDEX_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ia,
    input  logic        flush,
    output logic [31:0] id,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               start_req;
    logic               fill_done;
    logic               unused_ia_bits;

    // ia[31] is left out of the tag so supervisor/user aliases share a line.
    assign index          = ia[INDEX_W+1:2];
    assign tag            = ia[30:INDEX_W+2];
    assign unused_ia_bits = ^{ia[31], ia[1:0]};

    // The refill always targets the address latched when the request was issued.
    assign fill_index = mem_addr[INDEX_W+1:2];
    assign fill_tag   = mem_addr[30:INDEX_W+2];

    assign hit       = valid[index] && (tag_mem[index] == tag);
    assign start_req = (state_q == IDLE) && !hit && !flush;
    assign fill_done = (state_q == REQ) && mem_ack;

    assign id    = (!reset && hit && state_q == IDLE) ? data_mem[index] : 32'h0;
    assign stall = reset ? 1'b0 : !(hit && state_q == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_req) state_d = REQ;
            REQ:     if (mem_ack)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req  <= 1'b0;
            mem_addr <= 32'h0;
        end else if (start_req) begin
            mem_req  <= 1'b1;
            mem_addr <= {1'b0, ia[30:2], 2'b00};
        end else if (fill_done) begin
            mem_req  <= 1'b0;
        end
    end

    // A flush wins over a same-cycle fill, so the returning word is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          valid             <= '0;
        else if (flush)     valid             <= '0;
        else if (fill_done) valid[fill_index] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (fill_done && !flush) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: inputs change at the falling edge,
// outputs are checked shortly after, well clear of the rising edge.
module tb_imem_fetch_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ia;
    logic        flush;
    logic [31:0] id;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int errors  = 0;

    imem_fetch_responder #(.LINES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .ia        (ia),
        .flush     (flush),
        .id        (id),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Miss on a, hold the request for w extra cycles, then ack with d.
    task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input int w);
        logic [31:0] exp_addr;
        exp_addr = {1'b0, a[30:2], 2'b00};
        ia = a;
        #1;
        chk("miss_stall", {31'b0, stall}, 32'd1);
        chk("miss_no_req_yet", {31'b0, mem_req}, 32'd0);
        @(negedge clk); #1;
        chk("req_raised", {31'b0, mem_req}, 32'd1);
        chk("req_addr", mem_addr, exp_addr);
        for (int k = 0; k < w; k++) begin
            @(negedge clk); #1;
            chk("req_held", {31'b0, mem_req}, 32'd1);
            chk("req_addr_held", mem_addr, exp_addr);
            chk("req_stall", {31'b0, stall}, 32'd1);
        end
        mem_ack = 1'b1;
        mem_rdata = d;
        #1;
        chk("ack_cycle_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("fill_stall", {31'b0, stall}, 32'd0);
        chk("fill_id", id, d);
        chk("fill_req_clr", {31'b0, mem_req}, 32'd0);
    endtask

    task automatic do_hit(input logic [31:0] a, input logic [31:0] d);
        ia = a;
        #1;
        chk("hit_stall", {31'b0, stall}, 32'd0);
        chk("hit_id", id, d);
        @(negedge clk); #1;
        chk("hit_no_req", {31'b0, mem_req}, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        ia = 32'h8000_0000;
        flush = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_id", id, 32'h0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);

        // Cold start, ack in the third REQ cycle.
        @(negedge clk);
        reset = 1'b0;
        do_miss(32'h8000_0000, 32'h1234_5678, 2);

        // Fill the rest of the cache, then re-present every word.
        for (int i = 1; i < 16; i++)
            do_miss(32'h8000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 0);
        do_hit(32'h8000_0000, 32'h1234_5678);
        for (int i = 1; i < 16; i++)
            do_hit(32'h8000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i));

        // Conflict on line 0, then user-mode alias hits.
        do_miss(32'h8000_0040, 32'hBBBB_0040, 1);
        do_miss(32'h8000_0000, 32'hAAAA_0000, 0);
        do_hit(32'h0000_0000, 32'hAAAA_0000);

        // Flush: a hit in the flush cycle still returns data.
        ia = 32'h8000_0000;
        flush = 1'b1;
        #1;
        chk("flush_cycle_stall", {31'b0, stall}, 32'd0);
        chk("flush_cycle_id", id, 32'hAAAA_0000);
        @(negedge clk);
        flush = 1'b0;
        do_miss(32'h8000_0000, 32'hCCCC_0000, 1);

        // Flush coincident with ack drops the fill.
        ia = 32'h8000_0008;
        @(negedge clk); #1;
        chk("fa_req", {31'b0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        flush = 1'b1;
        mem_rdata = 32'hD0D0_0008;
        @(negedge clk);
        mem_ack = 1'b0;
        flush = 1'b0;
        #1;
        chk("fa_dropped_stall", {31'b0, stall}, 32'd1);
        chk("fa_dropped_id", id, 32'h0);
        chk("fa_idle_req", {31'b0, mem_req}, 32'd0);
        do_miss(32'h8000_0008, 32'hD1D1_0008, 0);

        // Flush during REQ without ack: fill still lands.
        ia = 32'h8000_000C;
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fr_req", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fr_req_kept", {31'b0, mem_req}, 32'd1);
        chk("fr_addr_kept", mem_addr, 32'h0000_000C);
        mem_ack = 1'b1;
        mem_rdata = 32'hE0E0_000C;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("fr_fill_stall", {31'b0, stall}, 32'd0);
        chk("fr_fill_id", id, 32'hE0E0_000C);
        chk("fr_prev_flushed", {31'b0, dut.valid[0]}, 32'd0);

        // Reset mid-refill; a stray ack right after release is ignored.
        @(negedge clk);
        ia = 32'h8000_0010;
        @(negedge clk); #1;
        chk("rm_req", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rm_req_drop", {31'b0, mem_req}, 32'd0);
        chk("rm_stall", {31'b0, stall}, 32'd0);
        chk("rm_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_0010;
        #1;
        chk("rm_idle_stall", {31'b0, stall}, 32'd1);
        chk("rm_idle_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("rm_ack_ignored_stall", {31'b0, stall}, 32'd1);
        chk("rm_new_req", {31'b0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'hF0F0_0010;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("rm_fill_id", id, 32'hF0F0_0010);

        // Ack in the first REQ cycle gives exactly two stall cycles.
        @(negedge clk);
        ia = 32'h8000_0014;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!stall) break;
            n++;
            if (mem_req) begin
                mem_ack = 1'b1;
                mem_rdata = 32'h5151_0014;
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        chk("b2b_stall_cycles", 32'(n), 32'd2);
        chk("b2b_id", id, 32'h5151_0014);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
